// File: rtl/sigmoid_rr_scheduler_pkg.sv
// Shared definitions for the sigmoid round-robin scheduler: fixed-point
// format constants, FSM state encoding and the result clamp helper.
package sigmoid_rr_scheduler_pkg;

  localparam int          FIX_FRAC_BITS = 27;
  localparam int          FIX_SIGN_BIT  = 31;
  localparam logic [31:0] FIX_ONE       = 32'(1) << FIX_FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Clamp a sign-magnitude result into [0, 1.0]; any negative value,
  // including negative zero, becomes +0.
  function automatic logic [31:0] sat_unit(input logic [31:0] y);
    logic [31:0] r;
    if (y[FIX_SIGN_BIT])
      r = 32'h0000_0000;
    else if (y[30:0] > FIX_ONE[30:0])
      r = FIX_ONE;
    else
      r = y;
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  // Walk the priority ring from lowest to highest priority so the
  // highest-priority asserted request is the last one written.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sigmoid_rr_scheduler.sv
// Shares one piecewise-linear sigmoid datapath among NUM_REQ requesters.
// One operand is in flight at a time; it is held on sig_x for EVAL_CYCLES
// before sig_y is sampled and returned on the valid/ready response port.
// Build option: define SIGMOID_SAT_EN to clamp results to [0, 1.0].
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; grant is issued combinationally
//   EVAL    | operand held on sig_x, cnt counts down to the sample point
//   RESP    | rsp_valid high, result held until rsp_ready at an edge
module sigmoid_rr_scheduler
  import sigmoid_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DATA_W      = 32,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         sig_x,
  input  logic [DATA_W-1:0]         sig_y,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [DATA_W-1:0]  y_f;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef SIGMOID_SAT_EN
  assign y_f = sat_unit(sig_y);
`else
  assign y_f = sig_y;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake outputs; grant is only visible in IDLE and
  // never while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!rst)
          req_ready = arb_grant;
        if (arb_any)
          state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (cnt == '0)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, round-robin pointer, eval timer and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      sig_x    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            sig_x  <= req_data[DATA_W*int'(arb_idx) +: DATA_W];
            rsp_id <= arb_idx;
            rr_ptr <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            cnt    <= CNT_W'(EVAL_CYCLES - 1);
          end
        end
        ST_EVAL: begin
          if (cnt == '0)
            rsp_data <= y_f;
          else
            cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Scoreboard bench for sigmoid_rr_scheduler. Instance u_a (EVAL_CYCLES=1)
// carries the arbitration, backpressure, saturation and wrap scenarios;
// instance u_b (EVAL_CYCLES=4) carries the mid-evaluation reset scenario.
module tb_sigmoid_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       sig_x, sig_y;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic              busy;

  // ---------------- instance B ----------------
  logic              b_rst;
  logic [NREQ-1:0]   b_req_valid;
  logic [NREQ*32-1:0] b_req_data;
  logic [NREQ-1:0]   b_req_ready;
  logic [31:0]       b_sig_x, b_sig_y;
  logic              b_rsp_valid;
  logic [31:0]       b_rsp_data;
  logic [IDW-1:0]    b_rsp_id;
  logic              b_rsp_ready;
  logic              b_busy;

  sigmoid_rr_scheduler #(.NUM_REQ(NREQ), .ID_W(IDW), .DATA_W(32), .EVAL_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sig_x(sig_x), .sig_y(sig_y), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy));

  sigmoid_rr_scheduler #(.NUM_REQ(NREQ), .ID_W(IDW), .DATA_W(32), .EVAL_CYCLES(4)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .sig_x(b_sig_x), .sig_y(b_sig_y), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .rsp_id(b_rsp_id), .rsp_ready(b_rsp_ready), .busy(b_busy));

  // Shared-datapath model: y = 0.5 + |x|/4 (signed), limited to [0, 1.0],
  // with two special operands that produce out-of-range results.
  function automatic logic [31:0] model(input logic [31:0] x);
    logic [31:0] m, y;
    m = {1'b0, x[30:0]} >> 2;
    if (x == 32'h7FFF_0001)      y = 32'h0840_0000;
    else if (x == 32'hFFFF_0001) y = 32'h8010_0000;
    else if (!x[31])             y = (m > 32'h03FF_FFEB) ? 32'h0800_0000 : 32'h0400_0015 + m;
    else                         y = (m > 32'h0400_0015) ? 32'h0000_0000 : 32'h0400_0015 - m;
    return y;
  endfunction

  always_comb sig_y   = model(sig_x);
  always_comb b_sig_y = model(b_sig_x);

`ifdef SIGMOID_SAT_EN
  localparam logic [31:0] EXP_SAT_HI = 32'h0800_0000;
  localparam logic [31:0] EXP_SAT_LO = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_SAT_HI = 32'h0840_0000;
  localparam logic [31:0] EXP_SAT_LO = 32'h8010_0000;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard queues and requester operand queues.
  logic [IDW-1:0] exp_grant[$];
  logic [33:0]    exp_rsp[$];
  logic [31:0]    rq[NREQ][$];
  int             rsp_times[$];
  int             cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected grants and responses when the DUT presents them.
  int   grant_cyc = 0;
  logic rsp_prev  = 1'b0;
  always @(negedge clk) begin
    logic [IDW-1:0] eg;
    logic [33:0]    er;
    if (req_ready != '0) begin
      if (exp_grant.size() == 0) begin
        chk("unexpected_grant", 32'(req_ready), 32'h0);
      end else begin
        eg = exp_grant.pop_front();
        chk("grant", 32'(req_ready), 32'(4'b0001 << eg));
      end
      grant_cyc = cyc;
    end
    if (rsp_valid && !rsp_prev && !rst)
      chk("latency", 32'(cyc - grant_cyc), 32'd2);
    rsp_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
      end else begin
        er = exp_rsp.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(er[33:32]));
        chk("rsp_data", rsp_data, er[31:0]);
      end
      rsp_times.push_back(cyc);
    end
  end

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      req_data[32*i +: 32] = (rq[i].size() != 0) ? rq[i][0] : 32'h0;
    end
  endtask

  // One clock: sample grants at the falling edge, retire granted operands
  // just after the rising edge that completes the handshake.
  task automatic step();
    logic [NREQ-1:0] gs;
    @(negedge clk);
    gs = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (gs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    refresh();
  endtask

  task automatic issue(input int id, input logic [31:0] x, input logic [31:0] y);
    rq[id].push_back(x);
    exp_grant.push_back(IDW'(id));
    exp_rsp.push_back({IDW'(id), y});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_grant.size() != 0 || exp_rsp.size() != 0) && t < 200) begin
      step();
      t++;
    end
    chk("drain_grants", 32'(exp_grant.size()), 32'd0);
    chk("drain_rsps", 32'(exp_rsp.size()), 32'd0);
    step();
    step();
  endtask

  task automatic reset_a();
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int idx0, k;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '1; req_data = '0;
    b_rst = 1'b1; b_req_valid = '0; b_req_data = '0; b_rsp_ready = 1'b1;
    #2;
    // Reset state, with requests asserted to prove the grant is forced low.
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sig_x", sig_x, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    step(); step();
    rst = 1'b0; b_rst = 1'b0;
    step();

    // 1: single request from requester 0.
    issue(0, 32'h0000_0000, 32'h0400_0015);
    refresh();
    drain();

    // 2: all four requesting after a fresh reset, order 0,1,2,3,0.
    reset_a();
    idx0 = rsp_times.size();
    issue(0, 32'h0040_0000, 32'h0410_0015);
    issue(1, 32'h8040_0000, 32'h03F0_0015);
    issue(2, 32'h0100_0000, 32'h0440_0015);
    issue(3, 32'h0000_0000, 32'h0400_0015);
    issue(0, 32'h0080_0000, 32'h0420_0015);
    refresh();
    drain();
    chk("rr_rsp_count", 32'(rsp_times.size() - idx0), 32'd5);
    if (rsp_times.size() >= idx0 + 5)
      for (int j = 1; j < 5; j++)
        chk("rr_spacing", 32'(rsp_times[idx0+j] - rsp_times[idx0+j-1]), 32'd3);

    // 3: backpressure in RESP, then requester 2 withdraws before any grant.
    rsp_ready = 1'b0;
    issue(1, 32'h0040_0000, 32'h0410_0015);
    refresh();
    k = 0;
    while (!rsp_valid && k < 20) begin step(); k++; end
    chk("bp_reach_resp", {31'd0, rsp_valid}, 32'd1);
    rq[2].push_back(32'h0000_0000);
    refresh();
    for (int j = 0; j < 10; j++) begin
      step();
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h0410_0015);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    rq[2].delete();
    refresh();
    rsp_ready = 1'b1;
    drain();
    step(); step();
    chk("drop_busy", {31'd0, busy}, 32'd0);

    // 4: saturation (rr_ptr is 2; each single request is granted directly).
    issue(0, 32'h7FFF_0001, EXP_SAT_HI);
    refresh();
    drain();
    issue(1, 32'hFFFF_0001, EXP_SAT_LO);
    refresh();
    drain();

    // 6: wrap - grant 3, then 4'b1001 gives 0 then 3.
    issue(3, 32'h0040_0000, 32'h0410_0015);
    refresh();
    drain();
    issue(0, 32'h0000_0000, 32'h0400_0015);
    issue(3, 32'h8040_0000, 32'h03F0_0015);
    refresh();
    drain();

    // 5: reset during EVAL on the EVAL_CYCLES=4 instance.
    b_req_valid = 4'b0010;
    b_req_data  = '0;
    @(negedge clk);
    chk("b_grant1", 32'(b_req_ready), 32'h2);
    @(posedge clk); #1;
    b_req_valid = '0;
    step();
    chk("b_busy_eval", {31'd0, b_busy}, 32'd1);
    b_rst = 1'b1;
    #1;
    chk("b_rst_busy", {31'd0, b_busy}, 32'd0);
    chk("b_rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_rst_sig_x", b_sig_x, 32'h0);
    step();
    b_rst = 1'b0;
    step();
    b_req_valid = 4'b1101;
    b_req_data  = {32'h0, 32'h0, 32'h0, 32'h0040_0000};
    @(negedge clk);
    chk("b_grant_after_rst", 32'(b_req_ready), 32'h1);
    @(posedge clk); #1;
    b_req_valid = '0;
    k = 1;
    while (!b_rsp_valid && k < 20) begin step(); k++; end
    chk("b_latency", 32'(k), 32'd5);
    chk("b_rsp_id", 32'(b_rsp_id), 32'd0);
    chk("b_rsp_data", b_rsp_data, 32'h0410_0015);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
